// File: rtl/risc16_pkg.sv
// risc16_pkg: opcode map, IR field positions and fetch FSM encoding
// shared across the RISC-16 core.
`default_nettype none

package risc16_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_SHL   = 4'h6,
        OP_SHR   = 4'h7,
        OP_BEQ   = 4'h8,
        OP_BNE   = 4'h9,
        OP_JMP   = 4'hA,
        OP_JAL   = 4'hB,
        OP_MVI   = 4'hC,
        OP_LOAD  = 4'hD,
        OP_STORE = 4'hE,
        OP_HALT  = 4'hF
    } opcode_e;

    localparam int IR_OPC_HI = 15;
    localparam int IR_OPC_LO = 12;
    localparam int IR_RD_HI  = 11;
    localparam int IR_RD_LO  = 8;
    localparam int IR_RS_HI  = 7;
    localparam int IR_RS_LO  = 4;
    localparam int IR_RT_HI  = 3;
    localparam int IR_RT_LO  = 0;
    localparam int IR_IMM_HI = 7;
    localparam int IR_IMM_LO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_pc_counter.sv
// pc_counter: program counter that loads (base + 1) when a fetch completes,
// wrapping modulo 2^AW.
`default_nettype none

module pc_counter #(
    parameter int             AW       = 16,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [AW-1:0] base,
    output logic [AW-1:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= base + AW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC + req/ack instruction fetch + IR field split.
// Optional ack-timeout abort enabled by defining FETCH_TIMEOUT_EN.
`default_nettype none

module instr_fetch_unit
    import risc16_pkg::*;
#(
    parameter int             AW       = 16,
    parameter int             DW       = 16,
    parameter logic [AW-1:0]  RESET_PC = '0,
    parameter int             TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pc_en,
    input  logic          jmp,
    input  logic [AW-1:0] jmp_addr,
    output logic [AW-1:0] imem_addr,
    output logic          imem_req,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    output logic [3:0]    opcode,
    output logic [3:0]    rd,
    output logic [3:0]    rs,
    output logic [3:0]    rt,
    output logic [7:0]    imm8,
    output logic [AW-1:0] pc,
    output logic          ir_valid,
    output logic          busy,
    output logic          fetch_err
);

    fetch_state_e  r_state;
    logic [DW-1:0] r_ir;
    logic          w_pc_load;

    // pc advances only when the instruction actually arrives, so a jump
    // leaves pc untouched until its target has been fetched.
    assign w_pc_load = (r_state == REQ) && imem_ack;

    pc_counter #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clk   (clk),
        .reset (reset),
        .load  (w_pc_load),
        .base  (imem_addr),
        .pc    (pc)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] r_wait_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign fetch_err        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ir      <= '0;
            imem_addr <= RESET_PC;
            imem_req  <= 1'b0;
            ir_valid  <= 1'b0;
            busy      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_wait_cnt <= '0;
            fetch_err  <= 1'b0;
`endif
        end else begin
            ir_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (pc_en) begin
                        imem_addr <= jmp ? jmp_addr : pc;
                        imem_req  <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= REQ;
`ifdef FETCH_TIMEOUT_EN
                        r_wait_cnt <= '0;
`endif
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        r_ir     <= imem_rdata;
                        imem_req <= 1'b0;
                        ir_valid <= 1'b1;
                        r_state  <= DONE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    // Abort leaves ir and pc as they were; only the flag records it.
                    else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        imem_req  <= 1'b0;
                        busy      <= 1'b0;
                        fetch_err <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
`endif
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    imem_req <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign opcode = r_ir[IR_OPC_HI:IR_OPC_LO];
    assign rd     = r_ir[IR_RD_HI:IR_RD_LO];
    assign rs     = r_ir[IR_RS_HI:IR_RS_LO];
    assign rt     = r_ir[IR_RT_HI:IR_RT_LO];
    assign imm8   = r_ir[IR_IMM_HI:IR_IMM_LO];

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scenario tasks plus randomized fetches checked
// against a transaction-level model of the fetch unit.
`default_nettype none

module tb_instr_fetch_unit;
    import risc16_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_en, jmp, imem_ack;
    logic [15:0] jmp_addr, imem_rdata;
    logic [15:0] imem_addr, pc;
    logic        imem_req, ir_valid, busy, fetch_err;
    logic [3:0]  opcode, rd, rs, rt;
    logic [7:0]  imm8;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: next sequential address and last captured instruction.
    logic [15:0] m_pc, m_ir;
    logic [15:0] e_addr, e_pc;

    // Observations from one fetch transaction.
    logic [15:0] o_addr, o_pc;
    logic [3:0]  o_opcode, o_rd, o_rs, o_rt;
    logic [7:0]  o_imm;
    logic        o_stable, o_valid, o_busy_done, o_req_done;
    logic        o_valid_after, o_busy_after, o_req_after;
    int          o_req_cycles;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .AW(16), .DW(16), .RESET_PC(16'h0000), .TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset), .pc_en(pc_en), .jmp(jmp), .jmp_addr(jmp_addr),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .opcode(opcode), .rd(rd), .rs(rs), .rt(rt),
        .imm8(imm8), .pc(pc), .ir_valid(ir_valid), .busy(busy), .fetch_err(fetch_err)
    );

    task automatic do_fetch(input logic j, input logic [15:0] a, input logic [15:0] d,
                            input int waits, input bit poke);
        e_addr = j ? a : m_pc;
        e_pc   = e_addr + 16'd1;
        pc_en = 1'b1; jmp = j; jmp_addr = a;
        @(posedge clk); #1;
        pc_en = 1'b0; jmp = 1'b0; jmp_addr = 16'($urandom);
        o_addr = imem_addr; o_stable = 1'b1; o_req_cycles = 0;
        for (int k = 0; k <= waits; k++) begin
            if (imem_req === 1'b1) o_req_cycles++;
            if (imem_addr !== o_addr || imem_req !== 1'b1) o_stable = 1'b0;
            pc_en = poke && (k == 0);
            imem_ack   = (k == waits);
            imem_rdata = (k == waits) ? d : 16'($urandom);
            @(posedge clk); #1;
        end
        imem_ack = 1'b0; pc_en = 1'b0;
        o_valid = ir_valid; o_busy_done = busy; o_req_done = imem_req;
        o_opcode = opcode; o_rd = rd; o_rs = rs; o_rt = rt; o_imm = imm8; o_pc = pc;
        @(posedge clk); #1;
        o_valid_after = ir_valid; o_busy_after = busy;
        @(posedge clk); #1;
        o_req_after = imem_req;
        m_pc = e_pc;
        m_ir = d;
    endtask

    task automatic test_reset;
        reset = 1'b1; pc_en = 1'b0; jmp = 1'b0; jmp_addr = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        #22 reset = 1'b0;
        @(posedge clk); #1;
        m_pc = 16'h0000; m_ir = 16'h0000;
        n_tests++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h expected 0000", pc); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        n_tests++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h expected 0000", imem_addr); end
        n_tests++; if ({opcode, rd, rs, rt, imm8} !== 24'h0) begin n_fail++; $display("FAIL reset_fields: got %h expected 0", {opcode, rd, rs, rt, imm8}); end
        n_tests++; if ({ir_valid, busy, fetch_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {ir_valid, busy, fetch_err}); end
    endtask

    task automatic test_zero_wait;
        do_fetch(1'b0, 16'h0, 16'hC312, 0, 1'b0);
        n_tests++; if (o_addr !== 16'h0000) begin n_fail++; $display("FAIL zw_addr: got %h expected 0000", o_addr); end
        n_tests++; if (o_req_cycles != 1) begin n_fail++; $display("FAIL zw_req_cycles: got %0d expected 1", o_req_cycles); end
        n_tests++; if (o_valid !== 1'b1 || o_busy_done !== 1'b1) begin n_fail++; $display("FAIL zw_valid_busy: got %b%b expected 11", o_valid, o_busy_done); end
        n_tests++; if ({o_opcode, o_rd, o_rs, o_rt, o_imm} !== {4'hC, 4'h3, 4'h1, 4'h2, 8'h12}) begin
            n_fail++; $display("FAIL zw_fields: got %h expected c31212", {o_opcode, o_rd, o_rs, o_rt, o_imm}); end
        n_tests++; if (o_pc !== 16'h0001) begin n_fail++; $display("FAIL zw_pc: got %h expected 0001", o_pc); end
        n_tests++; if (o_valid_after !== 1'b0 || o_busy_after !== 1'b0) begin n_fail++; $display("FAIL zw_pulse: got %b%b expected 00", o_valid_after, o_busy_after); end
        n_tests++; if (opcode !== 4'hC) begin n_fail++; $display("FAIL zw_hold: got %h expected c", opcode); end
    endtask

    task automatic test_wait_states;
        logic [15:0] words [3];
        logic [3:0]  ops [3];
        words[0] = 16'h1123; words[1] = 16'hD045; words[2] = 16'hC0FF;
        ops[0] = OP_ADD; ops[1] = OP_LOAD; ops[2] = OP_MVI;
        for (int i = 0; i < 3; i++) begin
            do_fetch(1'b0, 16'h0, words[i], 2, 1'b0);
            n_tests++; if (o_req_cycles != 3 || o_stable !== 1'b1) begin n_fail++; $display("FAIL ws_req_held[%0d]: got %0d/%b expected 3/1", i, o_req_cycles, o_stable); end
            n_tests++; if (o_addr !== e_addr) begin n_fail++; $display("FAIL ws_addr[%0d]: got %h expected %h", i, o_addr, e_addr); end
            n_tests++; if (o_opcode !== ops[i]) begin n_fail++; $display("FAIL ws_opcode[%0d]: got %h expected %h", i, o_opcode, ops[i]); end
        end
        n_tests++; if (pc !== m_pc) begin n_fail++; $display("FAIL ws_pc: got %h expected %h", pc, m_pc); end
    endtask

    task automatic test_jmp;
        do_fetch(1'b1, 16'h0040, 16'h2345, 1, 1'b0);
        n_tests++; if (o_addr !== 16'h0040) begin n_fail++; $display("FAIL jmp_addr: got %h expected 0040", o_addr); end
        n_tests++; if (o_pc !== 16'h0041) begin n_fail++; $display("FAIL jmp_pc: got %h expected 0041", o_pc); end
        do_fetch(1'b0, 16'h0, 16'h5AA5, 0, 1'b0);
        n_tests++; if (o_addr !== 16'h0041) begin n_fail++; $display("FAIL jmp_next_addr: got %h expected 0041", o_addr); end
    endtask

    task automatic test_wrap_drop;
        // jmp without pc_en must not start a fetch
        jmp = 1'b1; jmp_addr = 16'h1234;
        @(posedge clk); #1;
        jmp = 1'b0;
        n_tests++; if (imem_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL jmp_alone: got %b%b expected 00", imem_req, busy); end
        do_fetch(1'b1, 16'hFFFF, 16'h7001, 1, 1'b1);
        n_tests++; if (o_pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc: got %h expected 0000", o_pc); end
        n_tests++; if (o_req_after !== 1'b0 || o_req_done !== 1'b0) begin n_fail++; $display("FAIL drop_req: got %b%b expected 00", o_req_done, o_req_after); end
        do_fetch(1'b0, 16'h0, 16'hC0DE, 0, 1'b1);
        n_tests++; if (o_addr !== 16'h0000 || o_req_after !== 1'b0) begin n_fail++; $display("FAIL drop_zw: got %h/%b expected 0000/0", o_addr, o_req_after); end
    endtask

    task automatic test_random;
        logic        j;
        logic [15:0] a, d;
        int          w;
        for (int i = 0; i < 24; i++) begin
            j = ($urandom_range(0, 3) == 0);
            a = 16'($urandom);
            d = 16'($urandom);
            w = $urandom_range(0, 3);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            do_fetch(j, a, d, w, bit'($urandom_range(0, 1)));
            n_tests++; if (o_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h expected %h", i, o_addr, e_addr); end
            n_tests++; if (o_req_cycles != w + 1) begin n_fail++; $display("FAIL rnd_req_cycles[%0d]: got %0d expected %0d", i, o_req_cycles, w + 1); end
            n_tests++; if (o_pc !== e_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, o_pc, e_pc); end
            n_tests++; if ({o_opcode, o_rd, o_rs, o_rt} !== 16'((d >> 12) * 4096 + ((d >> 8) % 16) * 256 + ((d >> 4) % 16) * 16 + d % 16)
                           || o_imm !== 8'(d % 256)) begin
                n_fail++; $display("FAIL rnd_fields[%0d]: got %h/%h expected %h", i, {o_opcode, o_rd, o_rs, o_rt}, o_imm, d); end
            n_tests++; if (o_valid !== 1'b1 || o_valid_after !== 1'b0) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b%b expected 10", i, o_valid, o_valid_after); end
        end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout;
        int cnt;
        bit done;
        pc_en = 1'b1; jmp = 1'b0;
        @(posedge clk); #1;
        pc_en = 1'b0; imem_ack = 1'b0;
        cnt = 0; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (imem_req === 1'b1) begin
                cnt++;
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        n_tests++; if (!done) begin n_fail++; $display("FAIL to_bound: got req still high expected drop"); end
        n_tests++; if (cnt != 15) begin n_fail++; $display("FAIL to_req_cycles: got %0d expected 15", cnt); end
        n_tests++; if (fetch_err !== 1'b1 || busy !== 1'b0 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL to_flags: got %b%b%b expected 100", fetch_err, busy, ir_valid); end
        n_tests++; if (pc !== m_pc || {opcode, rd, rs, rt} !== m_ir) begin n_fail++; $display("FAIL to_unchanged: got %h/%h expected %h/%h", pc, {opcode, rd, rs, rt}, m_pc, m_ir); end
        do_fetch(1'b0, 16'h0, 16'h4321, 0, 1'b0);
        n_tests++; if (o_pc !== e_pc || fetch_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %h/%b expected %h/1", o_pc, fetch_err, e_pc); end
    endtask
`endif

    task automatic test_reset_mid_req;
        pc_en = 1'b1; jmp = 1'b1; jmp_addr = 16'h0123;
        @(posedge clk); #1;
        pc_en = 1'b0; jmp = 1'b0;
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL mid_pre_req: got %b expected 1", imem_req); end
        #3 reset = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        #1;
        n_tests++; if (imem_req !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_async_req: got %b%b expected 00", imem_req, busy); end
        n_tests++; if (pc !== 16'h0000 || opcode !== 4'h0 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL mid_async_state: got %h/%h/%b expected 0000/0/0", pc, opcode, fetch_err); end
        #10 reset = 1'b0;
        imem_ack = 1'b0;
        m_pc = 16'h0000; m_ir = 16'h0000;
        @(posedge clk); #1;
        n_tests++; if (imem_req !== 1'b0 || ir_valid !== 1'b0 || opcode !== 4'h0) begin n_fail++; $display("FAIL mid_discard: got %b%b%h expected 000", imem_req, ir_valid, opcode); end
        do_fetch(1'b0, 16'h0, 16'hE987, 1, 1'b0);
        n_tests++; if (o_addr !== 16'h0000 || o_pc !== 16'h0001 || o_opcode !== OP_STORE) begin
            n_fail++; $display("FAIL mid_recover: got %h/%h/%h expected 0000/0001/e", o_addr, o_pc, o_opcode); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_jmp();
        test_wrap_drop();
        test_random();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_req();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
